// File: rtl/uart_rx_8bit_if.sv
// Serial-in / byte-out bundle between a UART line and the 8-bit load register it feeds.
interface uart_rx_8bit_if;
    logic       rx_in;
    logic [7:0] data_out;
    logic       load;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    modport master (
        output rx_in,
        input  data_out, load, frame_err, parity_err, busy
    );

    modport slave (
        input  rx_in,
        output data_out, load, frame_err, parity_err, busy
    );
endinterface

// File: rtl/uart_rx_8bit.sv
// UART receiver: 8 data bits LSB first, sampled mid-bit at CLKS_PER_BIT clocks per bit.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx_8bit #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_rx_8bit_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY    = 3'd5;
`endif

    logic             sync1_q, sync2_q;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic [7:0]       data_q, data_d;
    logic             load_q, load_d;
    logic             frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic             par_bad_q, par_bad_d;
    logic             parity_err_q, parity_err_d;
`endif
    logic             rx_s;

    assign rx_s = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        load_d      = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    idx_d   = 3'd0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rx_s;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != ^shreg_q);
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                // A low stop bit means a break or lost framing: park until the line recovers.
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
`ifdef UART_RX_PARITY_EN
                    else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = IDLE;
                    end
`endif
                    else begin
                        data_d  = shreg_q;
                        load_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= 3'd0;
            shreg_q     <= 8'h00;
            data_q      <= 8'h00;
            load_q      <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= bus.rx_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            load_q      <= load_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.data_out  = data_q;
    assign bus.load      = load_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_8bit.sv
// Bench for uart_rx_8bit: directed scenarios plus random frames checked against a frame-level model
// that predicts each load/frame_err/parity_err event and its cycle from the start edge.
module tb_uart_rx_8bit;
    localparam int CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int LAT   = 2 + CLKS / 2 + (9 + PAR) * CLKS;
    localparam int FRAME = (10 + PAR) * CLKS;

    logic clk = 1'b0;
    logic rst_n;

    uart_rx_8bit_if bus();

    uart_rx_8bit #(.CLKS_PER_BIT(CLKS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;

    int         loadT[$];
    logic [7:0] loadD[$];
    int         ferrT[$];
    int         perrT[$];
    int         expLoadT[$];
    logic [7:0] expLoadD[$];
    int         expFerrT[$];
    int         expPerrT[$];
    logic [7:0] modelData = 8'h00;

    logic prevFlag = 1'b0;
    int   busyRun = 0;
    int   busyMax = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Record every strobe with its cycle; strobes must be exclusive and never back-to-back.
    always @(negedge clk) begin
        logic anyFlag;
        if (bus.load === 1'b1) begin
            loadT.push_back(cycleCnt);
            loadD.push_back(bus.data_out);
        end
        if (bus.frame_err === 1'b1) ferrT.push_back(cycleCnt);
        if (bus.parity_err === 1'b1) perrT.push_back(cycleCnt);
        anyFlag = bus.load | bus.frame_err | bus.parity_err;
        if (anyFlag) begin
            checkOutput("flagsExclusive",
                        32'(bus.load) + 32'(bus.frame_err) + 32'(bus.parity_err), 32'd1);
            checkOutput("flagGap", 32'(prevFlag), 32'd0);
        end
        prevFlag = anyFlag;
        if (bus.busy === 1'b1) busyRun++;
        else busyRun = 0;
        if (busyRun > busyMax) busyMax = busyRun;
    end

    task automatic sendBit(input logic v);
        bus.rx_in = v;
        repeat (CLKS) @(negedge clk);
    endtask

    task automatic idle(input int n);
        bus.rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame from a negedge and records the event the frame should produce.
    task automatic applyStimulus(input logic [7:0] b, input logic stopBit, input logic parBad);
        int t0;
        t0 = cycleCnt + 1;
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        if (PAR != 0) sendBit((^b) ^ parBad);
        sendBit(stopBit);
        if (!stopBit) begin
            expFerrT.push_back(t0 + LAT);
        end else if (PAR != 0 && parBad) begin
            expPerrT.push_back(t0 + LAT);
        end else begin
            expLoadT.push_back(t0 + LAT);
            expLoadD.push_back(b);
            modelData = b;
        end
    endtask

    task automatic verifyEvents(input string tag);
        checkOutput({tag, ".loadCount"}, 32'(loadT.size()), 32'(expLoadT.size()));
        for (int i = 0; i < loadT.size() && i < expLoadT.size(); i++) begin
            checkOutput({tag, ".loadCycle"}, 32'(loadT[i]), 32'(expLoadT[i]));
            checkOutput({tag, ".loadData"}, 32'(loadD[i]), 32'(expLoadD[i]));
        end
        checkOutput({tag, ".ferrCount"}, 32'(ferrT.size()), 32'(expFerrT.size()));
        for (int i = 0; i < ferrT.size() && i < expFerrT.size(); i++)
            checkOutput({tag, ".ferrCycle"}, 32'(ferrT[i]), 32'(expFerrT[i]));
        checkOutput({tag, ".perrCount"}, 32'(perrT.size()), 32'(expPerrT.size()));
        for (int i = 0; i < perrT.size() && i < expPerrT.size(); i++)
            checkOutput({tag, ".perrCycle"}, 32'(perrT[i]), 32'(expPerrT[i]));
        loadT.delete(); loadD.delete(); ferrT.delete(); perrT.delete();
        expLoadT.delete(); expLoadD.delete(); expFerrT.delete(); expPerrT.delete();
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".data_out"}, 32'(bus.data_out), 32'h0);
        checkOutput({tag, ".load"}, 32'(bus.load), 32'h0);
        checkOutput({tag, ".frame_err"}, 32'(bus.frame_err), 32'h0);
        checkOutput({tag, ".parity_err"}, 32'(bus.parity_err), 32'h0);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'h0);
    endtask

    initial begin
        logic [7:0] partial;
        logic [7:0] b;
        logic       stopBad;
        logic       parBad;
        logic       prevStopBad;
        int         gap;
        int         firstLoad;

        rst_n     = 1'b0;
        bus.rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
        idle(10);

        $display("[TB] single frame 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0);
        idle(20);
        verifyEvents("a5");

        $display("[TB] back-to-back 0x00 then 0xFF");
        applyStimulus(8'h00, 1'b1, 1'b0);
        applyStimulus(8'hFF, 1'b1, 1'b0);
        idle(20);
        if (loadT.size() == 2) begin
            firstLoad = loadT[0];
            checkOutput("b2bSpacing", 32'(loadT[1] - firstLoad), 32'(FRAME));
        end
        verifyEvents("b2b");

        $display("[TB] reset mid-frame then 0x3C");
        partial = 8'hE7;
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(partial[i]);
        checkOutput("midFrameBusy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        modelData = 8'h00;
        #1;
        checkAllZero("asyncReset");
        bus.rx_in = 1'b1;
        repeat (5) @(negedge clk);
        checkAllZero("heldReset");
        rst_n = 1'b1;
        idle(10);
        applyStimulus(8'h3C, 1'b1, 1'b0);
        idle(20);
        verifyEvents("resetMid");

        $display("[TB] start-bit glitch");
        busyMax   = 0;
        bus.rx_in = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        checkOutput("glitchBusyBound", 32'(busyMax >= 1 && busyMax <= 10), 32'h1);
        checkOutput("glitchIdle", 32'(bus.busy), 32'h0);
        verifyEvents("glitch");

        $display("[TB] framing error with held-low line, then 0x81");
        applyStimulus(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        checkOutput("breakBusy", 32'(bus.busy), 32'h1);
        checkOutput("breakDataHeld", 32'(bus.data_out), 32'(modelData));
        idle(4);
        checkOutput("breakRecovered", 32'(bus.busy), 32'h0);
        idle(10);
        applyStimulus(8'h81, 1'b1, 1'b0);
        idle(20);
        verifyEvents("frameErr");

`ifdef UART_RX_PARITY_EN
        $display("[TB] parity error on 0x07, then clean resend");
        applyStimulus(8'h07, 1'b1, 1'b1);
        checkOutput("parityDataHeld", 32'(bus.data_out), 32'(modelData));
        applyStimulus(8'h07, 1'b1, 1'b0);
        idle(20);
        verifyEvents("parity");
`endif

        $display("[TB] random frames");
        prevStopBad = 1'b0;
        for (int n = 0; n < 12; n++) begin
            b       = 8'($urandom_range(0, 255));
            stopBad = ($urandom_range(0, 3) == 0);
            parBad  = (PAR != 0) && ($urandom_range(0, 3) == 0);
            gap     = prevStopBad ? int'($urandom_range(4, 20)) : int'($urandom_range(0, 20));
            idle(gap);
            applyStimulus(b, !stopBad, parBad);
            prevStopBad = stopBad;
        end
        idle(30);
        checkOutput("randomDataOut", 32'(bus.data_out), 32'(modelData));
        verifyEvents("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
